// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing the RAM/I/O port between two masters.
// Master 0 is the CPU core; master 1 is the DMA/boot-loader engine.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   m_req                 per-master request, held with stable fields until m_done
//   m_read_type           per-master read_type (3'b000 = no read)
//   m_write_type          per-master write_type (2'b00 = no write)
//   m_address, m_data_in  per-master byte address and write data
//   m_done                one-cycle completion pulse to the granted master
//   m_data_out            registered read data, valid with m_done
//   m_error               completion was a watchdog abort
//   grant                 one-hot current owner, 0 when idle
//   ram_*                 downstream access fields and handshake
//
// Optional feature: define RAM_ARBITER_TIMEOUT_EN to abort a transaction that
// has not completed after TimeoutCycles cycles in WAIT.
module ram_arbiter #(
    parameter int AddressBitWidth = 32,
    parameter int DataBitWidth    = 32,
    parameter int TimeoutCycles   = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      m_req,
    input  logic [1:0][2:0]                 m_read_type,
    input  logic [1:0][1:0]                 m_write_type,
    input  logic [1:0][AddressBitWidth-1:0] m_address,
    input  logic [1:0][DataBitWidth-1:0]    m_data_in,
    output logic [1:0]                      m_done,
    output logic [DataBitWidth-1:0]         m_data_out,
    output logic                            m_error,
    output logic [1:0]                      grant,
    output logic                            ram_enable,
    output logic [2:0]                      ram_read_type,
    output logic [1:0]                      ram_write_type,
    output logic [AddressBitWidth-1:0]      ram_address,
    output logic [DataBitWidth-1:0]         ram_data_in,
    input  logic [DataBitWidth-1:0]         ram_data_out,
    input  logic                            ram_data_out_ready,
    input  logic                            ram_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t r_state;
    logic   r_owner;
    logic   r_last_owner;
    logic   w_pick;
    logic   w_complete;
    logic   w_timeout;

    // On a tie the master that did not own the previous transaction wins.
    assign w_pick     = (m_req == 2'b11) ? ~r_last_owner : m_req[1];
    assign w_complete = !ram_busy && (ram_read_type == 3'b000 || ram_data_out_ready);

`ifdef RAM_ARBITER_TIMEOUT_EN
    logic [15:0] r_cnt;
    // Held at zero outside WAIT, so it is cleared by the time WAIT starts.
    always_ff @(posedge clk)
        r_cnt <= (!rst_n || r_state != WAIT) ? 16'd0 : r_cnt + 16'd1;
    assign w_timeout = r_state == WAIT && !w_complete && r_cnt == 16'(TimeoutCycles - 1);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_owner        <= 1'b0;
            r_last_owner   <= 1'b1;
            grant          <= 2'b00;
            m_done         <= 2'b00;
            m_data_out     <= '0;
            m_error        <= 1'b0;
            ram_enable     <= 1'b0;
            ram_read_type  <= 3'b000;
            ram_write_type <= 2'b00;
            ram_address    <= '0;
            ram_data_in    <= '0;
        end else begin
            m_done  <= 2'b00;
            m_error <= 1'b0;
            case (r_state)
                IDLE: if (|m_req) begin
                    r_owner        <= w_pick;
                    grant          <= w_pick ? 2'b10 : 2'b01;
                    ram_enable     <= 1'b1;
                    ram_read_type  <= m_read_type[w_pick];
                    ram_write_type <= m_write_type[w_pick];
                    ram_address    <= m_address[w_pick];
                    ram_data_in    <= m_data_in[w_pick];
                    r_state        <= ISSUE;
                end
                // Completion is not sampled here: the cache needs a cycle to raise busy.
                ISSUE: r_state <= WAIT;
                WAIT: if (w_complete || w_timeout) begin
                    m_done         <= r_owner ? 2'b10 : 2'b01;
                    m_error        <= w_timeout;
                    if (w_timeout)
                        m_data_out <= '1;
                    else if (ram_read_type != 3'b000)
                        m_data_out <= ram_data_out;
                    r_last_owner   <= r_owner;
                    grant          <= 2'b00;
                    ram_enable     <= 1'b0;
                    ram_read_type  <= 3'b000;
                    ram_write_type <= 2'b00;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
